// File: rtl/cpu_step_controller.sv
// Clock-enable sequencer for the MEM-stage CPU: HALT, divided RUN, debounced STEP and BURST modes.
// Every output is registered; the CPU runs on clk_FPGA qualified by cpu_en.
module cpu_step_controller #(
    parameter int unsigned REFERENCE_CLOCK = 50000000,
    parameter int unsigned RUN_FREQUENCY   = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk_FPGA,
    input  logic        reset,
    input  logic [1:0]  mode_sel,
    input  logic        step_btn,
    input  logic [7:0]  burst_len,
    input  logic        halt_req,
    output logic        cpu_en,
    output logic        halted,
    output logic        busy,
    output logic [1:0]  state,
    output logic [15:0] step_count
);

    localparam int unsigned DIVISOR = REFERENCE_CLOCK / RUN_FREQUENCY;
    localparam int unsigned TickW   = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
    localparam int unsigned DbW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [TickW-1:0] TickMax = TickW'(DIVISOR - 1);
    localparam logic [DbW-1:0]   DbMax   = DbW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StHalt  = 2'b00,
        StRun   = 2'b01,
        StStep  = 2'b10,
        StBurst = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic               btn_meta_q, btn_sync_q;
    logic               db_level_q, db_level_d;
    logic [DbW-1:0]     db_cnt_q, db_cnt_d;
    logic               step_req_q, step_req_d;
    logic [TickW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [7:0]         remaining_q, remaining_d;
    logic               busy_q, busy_d;
    logic               halted_q, halted_d;
    logic               cpu_en_q, cpu_en_d;
    logic [15:0]        step_count_q, step_count_d;

    logic mode_change;
    logic burst_active;
    logic counting;
    logic tick;

    assign state_d      = state_e'(mode_sel);
    assign mode_change  = (state_d != state_q);
    assign burst_active = busy_q && (remaining_q != 8'd0);
    assign counting     = (state_q == StRun) || ((state_q == StBurst) && burst_active);
    assign tick         = counting && (tick_cnt_q == TickMax);

    // A level change is accepted only after DEBOUNCE_CYCLES disagreeing samples in a row.
    always_comb begin
        db_cnt_d   = '0;
        db_level_d = db_level_q;
        step_req_d = 1'b0;
        if (btn_sync_q != db_level_q) begin
            if (db_cnt_q == DbMax) begin
                db_level_d = btn_sync_q;
                step_req_d = btn_sync_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        tick_cnt_d = '0;
        if (mode_change) begin
            tick_cnt_d = '0;
        end else if (halted_q) begin
            tick_cnt_d = tick_cnt_q;
        end else if (counting) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        end
    end

    // Burst bookkeeping; busy lingers one cycle after remaining hits zero so it covers the last pulse.
    always_comb begin
        remaining_d = remaining_q;
        busy_d      = busy_q;
        if (mode_change) begin
            remaining_d = 8'd0;
            busy_d      = 1'b0;
        end else if ((state_q == StBurst) && !halted_q) begin
            if (busy_q) begin
                if (remaining_q == 8'd0) begin
                    busy_d = 1'b0;
                end else if (tick) begin
                    remaining_d = remaining_q - 8'd1;
                end
            end else if (step_req_q) begin
                remaining_d = burst_len;
                busy_d      = (burst_len != 8'd0);
            end
        end
    end

    always_comb begin
        cpu_en_d = 1'b0;
        if (!halted_q && !cpu_en_q) begin
            unique case (state_q)
                StHalt:  cpu_en_d = 1'b0;
                StRun:   cpu_en_d = tick;
                StStep:  cpu_en_d = step_req_q;
                StBurst: cpu_en_d = tick;
            endcase
        end
    end

    always_comb begin
        halted_d = halted_q;
        if (halt_req) begin
            halted_d = 1'b1;
        end else if (mode_sel == StHalt) begin
            halted_d = 1'b0;
        end
        step_count_d = step_count_q + {15'd0, cpu_en_q};
    end

    always_ff @(posedge clk_FPGA or negedge reset) begin
        if (!reset) begin
            state_q      <= StHalt;
            btn_meta_q   <= 1'b0;
            btn_sync_q   <= 1'b0;
            db_level_q   <= 1'b0;
            db_cnt_q     <= '0;
            step_req_q   <= 1'b0;
            tick_cnt_q   <= '0;
            remaining_q  <= 8'd0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
            cpu_en_q     <= 1'b0;
            step_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            btn_meta_q   <= step_btn;
            btn_sync_q   <= btn_meta_q;
            db_level_q   <= db_level_d;
            db_cnt_q     <= db_cnt_d;
            step_req_q   <= step_req_d;
            tick_cnt_q   <= tick_cnt_d;
            remaining_q  <= remaining_d;
            busy_q       <= busy_d;
            halted_q     <= halted_d;
            cpu_en_q     <= cpu_en_d;
            step_count_q <= step_count_d;
        end
    end

    assign cpu_en     = cpu_en_q;
    assign halted     = halted_q;
    assign busy       = busy_q;
    assign state      = state_q;
    assign step_count = step_count_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed bench for cpu_step_controller with DIVISOR=10 and a 4-sample debounce.
// Inputs change and outputs are sampled 1 time unit after the falling clock edge.
module tb_cpu_step_controller;

    logic        clk_FPGA = 1'b0;
    logic        reset;
    logic [1:0]  mode_sel;
    logic        step_btn;
    logic [7:0]  burst_len;
    logic        halt_req;
    logic        cpu_en;
    logic        halted;
    logic        busy;
    logic [1:0]  state;
    logic [15:0] step_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int pulse_cnt, first_pulse, last_pulse, prev_pulse;
    int back_to_back = 0;
    logic en_prev = 1'b0;
    int c0, cp, cs, cq, ch, cr;

    cpu_step_controller #(
        .REFERENCE_CLOCK(20),
        .RUN_FREQUENCY  (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk_FPGA  (clk_FPGA),
        .reset     (reset),
        .mode_sel  (mode_sel),
        .step_btn  (step_btn),
        .burst_len (burst_len),
        .halt_req  (halt_req),
        .cpu_en    (cpu_en),
        .halted    (halted),
        .busy      (busy),
        .state     (state),
        .step_count(step_count)
    );

    always #5 clk_FPGA = ~clk_FPGA;

    always @(posedge clk_FPGA) cyc++;

    // Pulse log: cycle index of each cpu_en, plus a back-to-back detector.
    always @(negedge clk_FPGA) begin
        if (cpu_en) begin
            if (en_prev) back_to_back++;
            if (pulse_cnt == 0) first_pulse = cyc;
            prev_pulse = last_pulse;
            last_pulse = cyc;
            pulse_cnt++;
        end
        en_prev = cpu_en;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_pulses();
        pulse_cnt   = 0;
        first_pulse = -1;
        last_pulse  = -1;
        prev_pulse  = -1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk_FPGA);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; mode_sel = 2'b00; step_btn = 1'b0; burst_len = 8'd0; halt_req = 1'b0;
        clear_pulses();
        wait_cyc(3);
        check_eq("rst_state", state, 0);
        check_eq("rst_cpu_en", cpu_en, 0);
        check_eq("rst_halted", halted, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_step_count", step_count, 0);
        reset = 1'b1;

        // RUN: pulses every 10 cycles, first one 11 cycles after mode_sel changes
        wait_cyc(5);
        c0 = cyc; mode_sel = 2'b01;
        wait_cyc(c0 + 1);
        check_eq("run_state", state, 1);
        wait_cyc(c0 + 105);
        check_eq("run_pulses", pulse_cnt, 10);
        check_eq("run_first", first_pulse, c0 + 11);
        check_eq("run_last", last_pulse, c0 + 101);
        check_eq("run_spacing", last_pulse - prev_pulse, 10);
        check_eq("run_step_count", step_count, 10);

        // STEP with a bouncing button, then stable high
        c0 = cyc; mode_sel = 2'b10; clear_pulses();
        wait_cyc(c0 + 3);
        for (int i = 0; i < 6; i++) begin
            step_btn = (i % 2 == 0);
            wait_cyc(cyc + 1);
        end
        cs = cyc; step_btn = 1'b1;
        wait_cyc(cs + 10);
        step_btn = 1'b0;
        wait_cyc(cs + 25);
        check_eq("step_pulses", pulse_cnt, 1);
        check_eq("step_latency", first_pulse, cs + 7);
        check_eq("step_count_after_step", step_count, 11);

        // BURST of 3, with a second press while busy that must be ignored
        c0 = cyc; mode_sel = 2'b11; burst_len = 8'd3; clear_pulses();
        wait_cyc(c0 + 3);
        cp = cyc; step_btn = 1'b1;
        wait_cyc(cp + 6);
        check_eq("burst_busy_before_load", busy, 0);
        wait_cyc(cp + 7);
        check_eq("burst_busy_at_load", busy, 1);
        wait_cyc(cp + 10); step_btn = 1'b0;
        wait_cyc(cp + 20); step_btn = 1'b1;
        wait_cyc(cp + 30); step_btn = 1'b0;
        wait_cyc(cp + 37);
        check_eq("burst_busy_last_pulse", busy, 1);
        wait_cyc(cp + 38);
        check_eq("burst_busy_drop", busy, 0);
        wait_cyc(cp + 45);
        check_eq("burst_pulses", pulse_cnt, 3);
        check_eq("burst_first", first_pulse, cp + 17);
        check_eq("burst_last", last_pulse, cp + 37);
        check_eq("burst_spacing", last_pulse - prev_pulse, 10);
        check_eq("burst_step_count", step_count, 14);

        // BURST with burst_len = 0
        cq = cyc; burst_len = 8'd0; step_btn = 1'b1; clear_pulses();
        wait_cyc(cq + 7);
        check_eq("burst0_busy", busy, 0);
        wait_cyc(cq + 10); step_btn = 1'b0;
        wait_cyc(cq + 30);
        check_eq("burst0_pulses", pulse_cnt, 0);

        // RUN with halt_req landing on a scheduled pulse
        c0 = cyc; mode_sel = 2'b01; clear_pulses();
        wait_cyc(c0 + 20); halt_req = 1'b1;
        wait_cyc(c0 + 21); halt_req = 1'b0;
        check_eq("halt_scheduled_en", cpu_en, 1);
        check_eq("halt_set", halted, 1);
        wait_cyc(c0 + 60);
        check_eq("halt_pulses", pulse_cnt, 2);
        check_eq("halt_state_tracks", state, 1);
        check_eq("halt_sticky", halted, 1);
        ch = cyc; mode_sel = 2'b00;
        wait_cyc(ch + 1);
        check_eq("halt_clear", halted, 0);
        check_eq("halt_mode_state", state, 0);
        wait_cyc(ch + 3);
        cr = cyc; mode_sel = 2'b01; clear_pulses();
        wait_cyc(cr + 15);
        check_eq("resume_first", first_pulse, cr + 11);
        check_eq("resume_pulses", pulse_cnt, 1);
        mode_sel = 2'b00;

        // BURST of 5 aborted by a mode change after two pulses
        c0 = cyc; mode_sel = 2'b11; burst_len = 8'd5;
        wait_cyc(c0 + 3);
        cp = cyc; step_btn = 1'b1; clear_pulses();
        wait_cyc(cp + 10); step_btn = 1'b0;
        wait_cyc(cp + 30);
        check_eq("abort_busy_before", busy, 1);
        mode_sel = 2'b00;
        wait_cyc(cp + 31);
        check_eq("abort_busy_after", busy, 0);
        wait_cyc(cp + 60);
        check_eq("abort_pulses", pulse_cnt, 2);
        check_eq("abort_step_count", step_count, 19);

        // Asynchronous reset while a RUN pulse is on the output
        c0 = cyc; mode_sel = 2'b01; clear_pulses();
        wait_cyc(c0 + 21);
        check_eq("pre_reset_en", cpu_en, 1);
        check_eq("pre_reset_count", step_count, 20);
        reset = 1'b0;
        #1;
        check_eq("async_rst_en", cpu_en, 0);
        check_eq("async_rst_state", state, 0);
        check_eq("async_rst_count", step_count, 0);
        check_eq("async_rst_busy", busy, 0);
        clear_pulses();
        wait_cyc(c0 + 23);
        reset = 1'b1; cr = cyc;
        wait_cyc(cr + 15);
        check_eq("post_reset_first", first_pulse, cr + 11);
        check_eq("post_reset_pulses", pulse_cnt, 1);

        // step_count wrap: preload near 0xFFFF instead of running 65535 ticks
        ch = cyc; mode_sel = 2'b00;
        wait_cyc(ch + 2);
        force dut.step_count_q = 16'hFFFE;
        wait_cyc(ch + 4);
        release dut.step_count_q;
        wait_cyc(ch + 5);
        check_eq("preload_count", step_count, 16'hFFFE);
        c0 = cyc; mode_sel = 2'b01;
        wait_cyc(c0 + 21);
        check_eq("wrap_ffff", step_count, 16'hFFFF);
        wait_cyc(c0 + 22);
        check_eq("wrap_zero", step_count, 16'h0000);

        check_eq("no_back_to_back", back_to_back, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
